// File: rtl/hatch_fetch_arb.sv
// Shared program/funtab memory port arbiter: round-robin between the cpu
// instruction fetch (48-bit, any byte address) and 32-bit funtab lookups.
module hatch_fetch_arb #(
  parameter int unsigned            MEM_AW      = 14,
  parameter logic [MEM_AW-1:0]      FUNTAB_BASE = MEM_AW'(14'h3F80)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [47:0]       if_instr,
  input  logic              ft_req,
  input  logic [6:0]        ft_idx,
  output logic              ft_ack,
  output logic [31:0]       ft_data,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned ASM_W = 96;

  typedef enum logic [2:0] {
    IDLE, IF_RD, IF_WAIT, FT_RD, FT_WAIT, ACK
  } state_t;

  state_t             state;
  logic               last_ft;
  logic               data_vld;
  logic [1:0]         off_q;
  logic [1:0]         rd_cnt;
  logic [1:0]         rx_cnt;
  logic [ASM_W-1:0]   asm_q;

  logic               grant_if_c;
  logic               grant_ft_c;
  logic [1:0]         last_rd_c;
  logic [MEM_AW-1:0]  ft_addr_c;
  logic [ASM_W-1:0]   asm_next_c;
  logic [47:0]        instr_c;
  logic               unused_c;

  assign unused_c = ^if_addr[31:MEM_AW+2];

  // Tie goes to whichever requester was not served last
  assign grant_if_c = if_req && (!ft_req || last_ft);
  assign grant_ft_c = ft_req && (!if_req || !last_ft);

  assign last_rd_c = (off_q == 2'd3) ? 2'd2 : 2'd1;
  assign ft_addr_c = FUNTAB_BASE + MEM_AW'(ft_idx);

  // Slot the returning word into the big-endian assembly buffer
  always_comb begin
    asm_next_c = asm_q;
    if (data_vld) begin
      case (rx_cnt)
        2'd0:    asm_next_c[95:64] = mem_rdata;
        2'd1:    asm_next_c[63:32] = mem_rdata;
        default: asm_next_c[31:0]  = mem_rdata;
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    instr_c = asm_next_c[95:48];
      2'd1:    instr_c = asm_next_c[87:40];
      2'd2:    instr_c = asm_next_c[79:32];
      default: instr_c = asm_next_c[71:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_ft  <= 1'b1;
      data_vld <= 1'b0;
      off_q    <= 2'd0;
      rd_cnt   <= 2'd0;
      rx_cnt   <= 2'd0;
      asm_q    <= '0;
      if_ack   <= 1'b0;
      if_instr <= '0;
      ft_ack   <= 1'b0;
      ft_data  <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      data_vld <= mem_rd;
      if_ack   <= 1'b0;
      ft_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if_c) begin
            state    <= IF_RD;
            last_ft  <= 1'b0;
            mem_rd   <= 1'b1;
            mem_addr <= if_addr[MEM_AW+1:2];
            off_q    <= if_addr[1:0];
            rd_cnt   <= 2'd0;
            rx_cnt   <= 2'd0;
            asm_q    <= '0;
          end else if (grant_ft_c) begin
            state    <= FT_RD;
            last_ft  <= 1'b1;
            mem_rd   <= 1'b1;
            mem_addr <= ft_addr_c;
          end
        end
        IF_RD: begin
          if (data_vld) begin
            asm_q  <= asm_next_c;
            rx_cnt <= rx_cnt + 2'd1;
          end
          if (rd_cnt == last_rd_c) begin
            mem_rd <= 1'b0;
            state  <= IF_WAIT;
          end else begin
            mem_addr <= mem_addr + MEM_AW'(1);
            rd_cnt   <= rd_cnt + 2'd1;
          end
        end
        IF_WAIT: begin
          asm_q    <= asm_next_c;
          if_instr <= instr_c;
          if_ack   <= 1'b1;
          state    <= ACK;
        end
        FT_RD: begin
          mem_rd <= 1'b0;
          state  <= FT_WAIT;
        end
        FT_WAIT: begin
          ft_data <= mem_rdata;
          ft_ack  <= 1'b1;
          state   <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hatch_fetch_arb.sv
// Directed bench for hatch_fetch_arb against a 1-cycle byte-pattern memory model.
module tb_hatch_fetch_arb;
  localparam int unsigned MEM_AW = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [47:0]       if_instr;
  logic              ft_req;
  logic [6:0]        ft_idx;
  logic              ft_ack;
  logic [31:0]       ft_data;
  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  logic [31:0]       mem [0:(1<<MEM_AW)-1];
  logic [MEM_AW-1:0] rd_q [$];
  int                tests = 0;
  int                failed = 0;

  hatch_fetch_arb #(.MEM_AW(MEM_AW), .FUNTAB_BASE(14'h3F80)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_instr(if_instr),
    .ft_req(ft_req), .ft_idx(ft_idx), .ft_ack(ft_ack), .ft_data(ft_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: data valid exactly one cycle after the strobe, garbage otherwise
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 32'hDEADBEEF;

  always @(negedge clk) begin
    tests++;
    assert (!(if_ack && ft_ack)) else begin
      failed++;
      $error("FAIL ack_overlap: observed if_ack=%0b ft_ack=%0b expected not both", if_ack, ft_ack);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until any ack (bounded); records read addresses seen on the way
  task automatic wait_ack(output int lat, output bit was_ft);
    lat = -1;
    was_ft = 1'b0;
    rd_q.delete();
    for (int i = 1; i <= 12; i++) begin
      step();
      if (mem_rd) rd_q.push_back(mem_addr);
      if (if_ack || ft_ack) begin
        lat = i;
        was_ft = ft_ack;
        break;
      end
    end
  endtask

  function automatic logic [41:0] rd_seq();
    logic [41:0] s = '0;
    for (int i = 0; i < rd_q.size() && i < 3; i++) s[41-14*i -: 14] = rd_q[i];
    return s;
  endfunction

  task automatic fetch(input string tag, input logic [31:0] addr, input int exp_lat,
                       input logic [47:0] exp_instr, input int nrd, input logic [41:0] exp_seq);
    int lat;
    bit was_ft;
    if_addr = addr;
    if_req  = 1'b1;
    wait_ack(lat, was_ft);
    check({tag, "_lat"},   64'(lat), 64'(exp_lat));
    check({tag, "_port"},  64'(was_ft), 64'(0));
    check({tag, "_instr"}, 64'(if_instr), 64'(exp_instr));
    check({tag, "_nrd"},   64'(rd_q.size()), 64'(nrd));
    check({tag, "_addrs"}, 64'(rd_seq()), 64'(exp_seq));
    step();
    if_req = 1'b0;
  endtask

  initial begin
    int          lat;
    bit          was_ft;
    int          acks;
    logic [47:0] held;

    for (int i = 0; i < (1 << MEM_AW); i++)
      mem[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    mem[14'h3F85] = 32'h00001001;

    rst = 1'b1; if_req = 1'b0; ft_req = 1'b0; if_addr = '0; ft_idx = '0;
    step(); step(); step();
    check("rst_if_ack",   64'(if_ack), 64'(0));
    check("rst_ft_ack",   64'(ft_ack), 64'(0));
    check("rst_mem_rd",   64'(mem_rd), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_if_instr", 64'(if_instr), 64'(0));
    check("rst_ft_data",  64'(ft_data), 64'(0));
    rst = 1'b0;
    step();

    // Scenario 4: both held high from reset -> IF, FT, IF, FT
    if_addr = 32'h0000000C; ft_idx = 7'd5;
    if_req = 1'b1; ft_req = 1'b1;
    wait_ack(lat, was_ft);
    check("rr1_port",  64'(was_ft), 64'(0));
    check("rr1_lat",   64'(lat), 64'(4));
    check("rr1_instr", 64'(if_instr), 64'h0C0D0E0F1011);
    wait_ack(lat, was_ft);
    check("rr2_port",  64'(was_ft), 64'(1));
    check("rr2_lat",   64'(lat), 64'(4));
    check("rr2_data",  64'(ft_data), 64'h00001001);
    wait_ack(lat, was_ft);
    check("rr3_port",  64'(was_ft), 64'(0));
    check("rr3_lat",   64'(lat), 64'(5));
    wait_ack(lat, was_ft);
    check("rr4_port",  64'(was_ft), 64'(1));
    check("rr4_lat",   64'(lat), 64'(4));
    step();
    if_req = 1'b0; ft_req = 1'b0;
    step();

    // Scenarios 1, 2: aligned and offset-3 fetches
    fetch("s1", 32'h0000000C, 4, 48'h0C0D0E0F1011, 2, {14'd3, 14'd4, 14'd0});
    fetch("s2", 32'h00000007, 5, 48'h0708090A0B0C, 3, {14'd1, 14'd2, 14'd3});
    held = if_instr;

    // Scenario 3: funtab lookup; if_instr must hold
    ft_idx = 7'd5; ft_req = 1'b1;
    wait_ack(lat, was_ft);
    check("s3_port",  64'(was_ft), 64'(1));
    check("s3_lat",   64'(lat), 64'(3));
    check("s3_data",  64'(ft_data), 64'h00001001);
    check("s3_addrs", 64'(rd_seq()), 64'({14'h3F85, 14'd0, 14'd0}));
    check("s3_hold",  64'(if_instr), 64'(held));
    step();
    ft_req = 1'b0;

    // Scenario 5: word-address wrap, high address bits ignored
    fetch("s5", 32'h0000FFFF, 5, 48'hFF0001020304, 3, {14'h3FFF, 14'h0000, 14'h0001});
    fetch("s5hi", 32'hABCD000C, 4, 48'h0C0D0E0F1011, 2, {14'd3, 14'd4, 14'd0});

    // Scenario 6: reset during the second read aborts the fetch
    if_addr = 32'h0000000C; if_req = 1'b1;
    step();
    step();
    check("s6_rd2",    64'(mem_rd), 64'(1));
    check("s6_addr2",  64'(mem_addr), 64'(4));
    rst = 1'b1;
    step();
    rst = 1'b0; if_req = 1'b0;
    check("s6_mem_rd", 64'(mem_rd), 64'(0));
    check("s6_ack",    64'(if_ack), 64'(0));
    check("s6_addr",   64'(mem_addr), 64'(0));
    check("s6_instr",  64'(if_instr), 64'(0));
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if_ack || ft_ack || mem_rd) acks++;
    end
    check("s6_quiet", 64'(acks), 64'(0));
    fetch("s6b", 32'h0000000C, 4, 48'h0C0D0E0F1011, 2, {14'd3, 14'd4, 14'd0});

    step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
